// File: rtl/buffer_lru_lookup.sv
// Sequential first-match search of a live slot array: one slot per cycle, IDLE -> SCAN -> DONE.
// Optional miss counter output enabled by defining BUFFER_LRU_LOOKUP_MISS_CNT_EN.
module buffer_lru_lookup #(
    parameter int WIDTH    = 16,
    parameter int BUF_SIZE = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               req_i,
    input  logic [WIDTH-1:0]                   key_i,
    input  logic [BUF_SIZE-1:0][WIDTH-1:0]     buf_array_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               hit_o,
    output logic [$clog2(BUF_SIZE)-1:0]        idx_o
`ifdef BUFFER_LRU_LOOKUP_MISS_CNT_EN
    ,
    output logic [15:0]                        miss_cnt_o
`endif
);
    localparam int IDX_W = $clog2(BUF_SIZE);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(BUF_SIZE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   key_q;
    logic               hit_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   slot_val;
    logic               slot_match;

    // Empty slots (value 0) are never a match, so a zero key always misses.
    assign slot_val   = buf_array_i[cnt_q];
    assign slot_match = (slot_val == key_q) && (slot_val != '0);

`ifdef BUFFER_LRU_LOOKUP_MISS_CNT_EN
    logic [15:0] miss_cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            miss_cnt_q <= '0;
        else if (state_q == SCAN && !slot_match && cnt_q == LAST_SLOT && miss_cnt_q != 16'hFFFF)
            miss_cnt_q <= miss_cnt_q + 16'd1;
    end
    assign miss_cnt_o = miss_cnt_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        key_q   <= key_i;
                        cnt_q   <= '0;
                        hit_q   <= 1'b0;
                        idx_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (slot_match) begin
                        hit_q   <= 1'b1;
                        idx_q   <= cnt_q;
                        state_q <= DONE;
                    end else if (cnt_q == LAST_SLOT) begin
                        hit_q   <= 1'b0;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign hit_o  = hit_q;
    assign idx_o  = idx_q;

endmodule

// File: doc/buffer_lru_lookup.md
BUFFER_LRU_LOOKUP -- requirements
Module: buffer_lru_lookup

Interface
REQ-001 Parameter WIDTH, default 16, bit width of one buffer entry and of the key.
REQ-002 Parameter BUF_SIZE, default 8, number of buffer slots; power of two, at least 2.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 req_i  input  1  lookup request; sampled only in IDLE.
REQ-006 key_i  input  WIDTH  value to search for; captured when a request is accepted.
REQ-007 buf_array_i  input  [BUF_SIZE-1:0][WIDTH-1:0]  slot contents, packed in the same layout as buffer_lru buf_array_o; value 0 marks an empty slot.
REQ-008 busy_o  output  1  high while in SCAN or DONE.
REQ-009 done_o  output  1  one-cycle pulse marking a completed lookup.
REQ-010 hit_o  output  1  result of the last lookup: 1 = key found.
REQ-011 idx_o  output  $clog2(BUF_SIZE)  slot index of the hit; 0 on a miss.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-013 In IDLE with req_i=1 at edge E0: the block SHALL latch key_i, clear the slot counter to 0 and enter SCAN.
REQ-014 In SCAN: the block SHALL compare buf_array_i[cnt] with the latched key, one slot per cycle, starting at slot 0; slot k is compared in the cycle after edge E_k.
REQ-015 Match at slot k: at E_{k+1} the block SHALL enter DONE with hit_o=1 and idx_o=k, and the scan SHALL stop at the first (lowest-index) match.
REQ-016 No match at slot BUF_SIZE-1: at E_BUF_SIZE the block SHALL enter DONE with hit_o=0 and idx_o=0.
REQ-017 A slot holding 0 SHALL never match, so key 0 always misses after the full scan.
REQ-018 done_o SHALL be high for exactly the one cycle spent in DONE; the next edge SHALL return the FSM to IDLE.
REQ-019 hit_o and idx_o SHALL hold their values from entry into DONE until the next accepted request, which SHALL clear both to 0 at E0.
REQ-020 req_i SHALL be ignored while busy_o=1, and no request queuing SHALL take place.
REQ-021 A request in the IDLE cycle that directly follows DONE SHALL be accepted (back-to-back lookups).
REQ-022 buf_array_i SHALL be sampled live; a slot changed during the scan is compared at its current value when reached.

Reset
REQ-023 rst_i=1 at any edge, including mid-SCAN or in DONE, SHALL force IDLE with busy_o=0, done_o=0, hit_o=0, idx_o=0, slot counter 0, latched key 0, and no done_o pulse.
REQ-024 Reset SHALL take priority over req_i on the same edge.

Configuration
REQ-025 Macro BUFFER_LRU_LOOKUP_MISS_CNT_EN defined: the block SHALL add output miss_cnt_o [15:0], reset to 0, incremented on every DONE entry with hit_o=0, saturating at 16'hFFFF.
REQ-026 Macro BUFFER_LRU_LOOKUP_MISS_CNT_EN undefined: the miss_cnt_o port and its counter SHALL be absent, with all other behaviour identical.

Verification (WIDTH=16, BUF_SIZE=8, buf_array_i={108,111,109,110,112,105,106,107}, slot 0 first)
REQ-027 key 110 at E0 -> done_o high in the cycle after E4, hit_o=1, idx_o=3.
REQ-028 key 100 -> done_o after E8, hit_o=0, idx_o=0; with the macro defined, miss_cnt_o 0->1.
REQ-029 buffer all zero, key 0 -> miss after 8 compare cycles, hit_o=0; key 108 on the original buffer then gives hit at idx_o=0 with done_o after E1.
REQ-030 key 107 accepted, req_i held high with key 111 throughout the scan -> only the 107 lookup completes (idx_o=7); 111 is accepted in the IDLE cycle after DONE and gives idx_o=1.
REQ-031 rst_i pulsed at E3 of a key-107 scan -> no done_o, all outputs 0 at the next edge; a new key-105 request then gives idx_o=5.
